keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad (Pmod-style: active-low column drives, pulled-up row inputs) and reports debounced key presses. It is the input-side counterpart of the seven-segment scan path: the display path drives multiplexed outputs, and this block drives columns and reads rows back. It runs from the nominal 25 MHz system clock and feeds key codes and strobes to the MicroBlaze GPIO/register logic.

Parameters:
SCAN_DIV, 24999, terminal count of the column-step divider; one column step every SCAN_DIV+1 clocks (1 kHz at 25 MHz). Minimum value is 2.
DEBOUNCE_SCANS, 4, number of consecutive full scans needed to accept a press or a release. Minimum value is 2.

Ports:
clock_in  input  1  system clock, nominally 25 MHz
reset  input  1  asynchronous, active-high reset
row_in  input  4  keypad rows, active-low, asynchronous to clock_in
col_out  output  4  keypad column drive, active-low, exactly one bit low at all times
key_code  output  4  code of the accepted key, {col[1:0], row[1:0]}; holds its value until the next accepted press
key_valid  output  1  one-clock pulse when a press is accepted
key_held  output  1  high while the accepted key is considered pressed

Behaviour:
- Reset values: col_out=4'b1110, key_code=0, key_valid=0, key_held=0, divider=0, column index=0, FSM=IDLE, debounce count=0, scan accumulator cleared.
- row_in passes through a 2-flop synchronizer before any use.
- Divider:
  - Counts 0..SCAN_DIV and wraps to 0.
  - "tick" is high for one clock_in cycle when the count equals SCAN_DIV.
- Column scan, on each tick:
  - Sample the synchronized rows for the current column.
  - Advance the column index 0->1->2->3->0.
  - col_out updates on that same edge, so each column settles for a full tick period before it is sampled.
  - col_out for index i is all ones except bit i, which is 0.
- Scan result:
  - Within one scan (columns 0..3), record the first pressed key in order of ascending code: lowest column first, then lowest row.
  - A row is pressed when its synchronized bit is 0.
  - At the tick that samples column 3, form the scan result {pressed, code}, including column 3's own sample. Clear the accumulator for the next scan.
  - Multiple keys pressed: the lowest code wins.
- Debounce FSM (4 states). It evaluates only on scan-complete ticks; cnt is the debounce count.
  - IDLE: pressed -> go to PRESS_CHK, cand=code, cnt=1. Otherwise stay.
  - PRESS_CHK:
    - Pressed with code==cand: cnt++. When cnt reaches DEBOUNCE_SCANS, go to HELD, load key_code=cand, pulse key_valid.
    - Pressed with a different code: cand=code, cnt=1.
    - Not pressed: go to IDLE.
  - HELD (key_held=1):
    - Not pressed, or code!=key_code: go to RELEASE_CHK, cnt=1.
    - Otherwise stay.
  - RELEASE_CHK (key_held stays 1):
    - Same key pressed again: go to HELD.
    - Otherwise cnt++. When cnt reaches DEBOUNCE_SCANS, go to IDLE and key_held=0 on that edge.
- key_valid is registered. It is high only in the clock cycle following the scan-complete tick edge that accepted the press, and it never holds two cycles.
- Latency: scan period is 4*(SCAN_DIV+1) clocks (4 ms at defaults). A stable press is accepted at the end of its DEBOUNCE_SCANS-th full scan.
- A release never produces key_valid. A new key after a release passes through IDLE->PRESS_CHK and needs a full debounce.
- Reset asserted mid-operation: everything returns to reset values immediately, and no pending pulse is emitted.

Decomposition:
- Package keypad_pkg:
  - FSM state encoding (IDLE, PRESS_CHK, HELD, RELEASE_CHK)
  - KEY_CODE_W=4
  - NUM_COLS=4
  - COL_RESET=4'b1110
- Sub-module scan_tick_gen: the SCAN_DIV divider producing the one-cycle tick.
- Column scan, synchronizer and FSM stay in keypad_scanner.

Test Plan:
All tests use SCAN_DIV=3 and DEBOUNCE_SCANS=3, giving a 16-clock scan.
1. Reset release, rows all 1 -> col_out=1110; it then cycles 1101, 1011, 0111, 1110, each lasting 4 clocks. key_valid, key_held and key_code stay 0.
2. Drive row_in=1101 only while col_out=1011 (key col2,row1), stable for 3+ scans -> exactly one key_valid pulse after the 3rd scan completes, key_code=4'b1001, key_held=1.
3. Key col2,row1 present for scans 1-2, absent in scan 3 -> no key_valid, key_held=0, FSM back in IDLE.
4. Keys col0,row3 and col1,row0 pressed together and stable -> key_code=4'b0011, single key_valid pulse.
5. After test 2, release -> key_held drops after 3 empty scans with no key_valid. Re-pressing the same key produces a new single pulse after 3 scans.
6. Assert reset during PRESS_CHK (after 2 good scans) -> col_out=1110, key_valid=0, key_held=0, key_code=0. A subsequent press needs a full 3 scans.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner.
// Latency: n/a (types, constants and a column-drive helper only).
// Backpressure: n/a.
//
// Contents: debounce FSM state encoding, key code / matrix geometry,
// column-drive reset pattern and a helper that maps a column index to
// its active-low drive pattern.
package keypad_pkg;

   localparam int KEY_CODE_W = 4;
   localparam int NUM_COLS   = 4;
   localparam int NUM_ROWS   = 4;
   localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_PRESS_CHK   = 2'd1,
      ST_HELD        = 2'd2,
      ST_RELEASE_CHK = 2'd3
   } state_t;

   // Active-low drive: all columns released except the selected one.
   function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
      return ~(NUM_COLS'(1) << idx);
   endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Column-step divider: counts 0..SCAN_DIV and flags the terminal count.
// Latency: o_tick is combinational from the counter, high one cycle in SCAN_DIV+1.
// Backpressure: none; free-running.
//
// Ports:
//   clock_in  system clock
//   reset     asynchronous, active-high
//   o_tick    one-cycle pulse when the count equals SCAN_DIV
module scan_tick_gen #(
   parameter int SCAN_DIV = 24999
) (
   input  logic clock_in,
   input  logic reset,
   output logic o_tick
);

   localparam int DIV_W = (SCAN_DIV < 2) ? 2 : $clog2(SCAN_DIV + 1);

   logic [DIV_W-1:0] r_count;
   logic             w_terminal;

   assign w_terminal = (r_count == DIV_W'(SCAN_DIV));
   assign o_tick     = w_terminal;

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_terminal) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + DIV_W'(1);
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, row synchronizer, per-scan key pick and debounce.
// Latency: a stable press is accepted at the end of its DEBOUNCE_SCANS-th full scan (4*(SCAN_DIV+1) clocks each).
// Backpressure: none; key_valid is a single-cycle strobe the consumer must take when offered.
//
// Ports:
//   clock_in   system clock (nominally 25 MHz)
//   reset      asynchronous, active-high
//   row_in     keypad rows, active-low, asynchronous to clock_in
//   col_out    active-low column drive, exactly one bit low
//   key_code   {col[1:0], row[1:0]} of the last accepted key
//   key_valid  one-cycle pulse on an accepted press
//   key_held   high while the accepted key is considered pressed
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 24999,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                  clock_in,
   input  logic                  reset,
   input  logic [NUM_ROWS-1:0]   row_in,
   output logic [NUM_COLS-1:0]   col_out,
   output logic [KEY_CODE_W-1:0] key_code,
   output logic                  key_valid,
   output logic                  key_held
);

   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

   logic                  w_tick;
   logic [NUM_ROWS-1:0]   r_row_meta;
   logic [NUM_ROWS-1:0]   r_row_sync;
   logic [1:0]            r_col_idx;
   logic [NUM_COLS-1:0]   r_col_out;
   logic                  r_acc_vld;
   logic [KEY_CODE_W-1:0] r_acc_code;

   logic                  w_col_hit;
   logic [1:0]            w_col_row;
   logic                  w_scan_done;
   logic                  w_scan_pressed;
   logic [KEY_CODE_W-1:0] w_scan_code;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [KEY_CODE_W-1:0] r_cand;
   logic [KEY_CODE_W-1:0] w_cand_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [KEY_CODE_W-1:0] r_key_code;
   logic [KEY_CODE_W-1:0] w_code_nxt;
   logic                  r_key_valid;
   logic                  w_valid_nxt;
   logic                  r_key_held;

   scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clock_in (clock_in),
      .reset    (reset),
      .o_tick   (w_tick)
   );

   // Rows idle high (pull-ups), so the synchronizer resets to "nothing pressed".
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         r_row_meta <= '1;
         r_row_sync <= '1;
      end else begin
         r_row_meta <= row_in;
         r_row_sync <= r_row_meta;
      end
   end

   // Lowest pressed row in the column currently being sampled.
   always_comb begin
      w_col_hit = 1'b0;
      w_col_row = '0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (!r_row_sync[r]) begin
            w_col_hit = 1'b1;
            w_col_row = 2'(r);
         end
      end
   end

   // Columns are visited in ascending order, so an earlier hit in this scan
   // always has a lower code than anything found now.
   assign w_scan_done    = w_tick && (r_col_idx == 2'(NUM_COLS - 1));
   assign w_scan_pressed = r_acc_vld | w_col_hit;
   assign w_scan_code    = r_acc_vld ? r_acc_code : {r_col_idx, w_col_row};

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         r_col_idx  <= '0;
         r_col_out  <= COL_RESET;
         r_acc_vld  <= 1'b0;
         r_acc_code <= '0;
      end else if (w_tick) begin
         r_col_idx <= r_col_idx + 2'd1;
         r_col_out <= col_drive(r_col_idx + 2'd1);
         if (w_scan_done) begin
            r_acc_vld  <= 1'b0;
            r_acc_code <= '0;
         end else begin
            r_acc_vld  <= w_scan_pressed;
            r_acc_code <= w_scan_code;
         end
      end
   end

   // Debounce FSM: state register.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cand      <= '0;
         r_cnt       <= '0;
         r_key_code  <= '0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cand      <= w_cand_nxt;
         r_cnt       <= w_cnt_nxt;
         r_key_code  <= w_code_nxt;
         r_key_valid <= w_valid_nxt;
         r_key_held  <= (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_CHK);
      end
   end

   // Debounce FSM: next state, evaluated only on scan-complete ticks.
   always_comb begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
      w_cnt_nxt   = r_cnt;
      w_code_nxt  = r_key_code;
      w_valid_nxt = 1'b0;
      if (w_scan_done) begin
         case (r_state)
            ST_IDLE: begin
               if (w_scan_pressed) begin
                  w_state_nxt = ST_PRESS_CHK;
                  w_cand_nxt  = w_scan_code;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end
            ST_PRESS_CHK: begin
               if (!w_scan_pressed) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_scan_code != r_cand) begin
                  w_cand_nxt = w_scan_code;
                  w_cnt_nxt  = CNT_W'(1);
               end else if (r_cnt + CNT_W'(1) == CNT_W'(DEBOUNCE_SCANS)) begin
                  w_state_nxt = ST_HELD;
                  w_code_nxt  = r_cand;
                  w_valid_nxt = 1'b1;
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_HELD: begin
               if (!w_scan_pressed || (w_scan_code != r_key_code)) begin
                  w_state_nxt = ST_RELEASE_CHK;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end
            ST_RELEASE_CHK: begin
               if (w_scan_pressed && (w_scan_code == r_key_code)) begin
                  w_state_nxt = ST_HELD;
               end else if (r_cnt + CNT_W'(1) == CNT_W'(DEBOUNCE_SCANS)) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign col_out   = r_col_out;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a 16-clock scan (SCAN_DIV=3, DEBOUNCE_SCANS=3).
// A keypad model answers the column drive; a per-scan reference tracks press/release streaks.
// Stimulus: directed scenarios followed by randomized key sets held for whole scans.
module tb_keypad_scanner;

   localparam int SCAN_DIV  = 3;
   localparam int DEB       = 3;
   localparam int STEP_CLKS = SCAN_DIV + 1;
   localparam int SCAN_CLKS = 4 * STEP_CLKS;

   logic        clock_in = 1'b0;
   logic        reset;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;

   logic [15:0] keys;
   logic [15:0] rk;
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc;

   // Reference model: press streak while not held, miss streak while held.
   bit          m_held;
   int          m_key;
   int          m_streak_code;
   int          m_streak_len;
   int          m_miss;
   bit          m_valid;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
      .clock_in  (clock_in),
      .reset     (reset),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clock_in = ~clock_in;

   // Physical keypad: a pressed key shorts its row to a driven-low column.
   always_comb begin
      row_in = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (!col_out[c] && keys[c*4+r]) row_in[r] = 1'b0;
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic model_clear();
      m_held = 0; m_key = 0; m_streak_code = 0; m_streak_len = 0; m_miss = 0; m_valid = 0;
   endtask

   task automatic model_scan(input logic [15:0] k);
      int code;
      code = -1;
      for (int i = 15; i >= 0; i--) if (k[i]) code = i;
      m_valid = 0;
      if (!m_held) begin
         if (code < 0) begin
            m_streak_len = 0;
         end else begin
            if (m_streak_len > 0 && code == m_streak_code) m_streak_len++;
            else begin
               m_streak_code = code;
               m_streak_len  = 1;
            end
            if (m_streak_len == DEB) begin
               m_held = 1; m_key = code; m_valid = 1; m_streak_len = 0; m_miss = 0;
            end
         end
      end else begin
         if (code == m_key) m_miss = 0;
         else begin
            m_miss++;
            if (m_miss == DEB) begin
               m_held = 0; m_miss = 0; m_streak_len = 0;
            end
         end
      end
   endtask

   // One full scan with key set k; every clock is checked on the falling edge.
   task automatic run_scan(input logic [15:0] k);
      logic [3:0] exp_col;
      keys = k;
      for (int i = 0; i < SCAN_CLKS; i++) begin
         @(posedge clock_in);
         cyc++;
         m_valid = 0;
         if (cyc % SCAN_CLKS == 0) model_scan(k);
         @(negedge clock_in);
         exp_col = ~(4'b0001 << ((cyc / STEP_CLKS) % 4));
         chk_eq("col_out",   32'(col_out),   32'(exp_col));
         chk_eq("key_valid", 32'(key_valid), 32'(m_valid));
         chk_eq("key_held",  32'(key_held),  32'(m_held));
         chk_eq("key_code",  32'(key_code),  32'(m_key));
      end
   endtask

   task automatic apply_reset();
      @(negedge clock_in);
      reset = 1'b1;
      #1;
      chk_eq("rst_col_out",   32'(col_out),   32'h0000_000e);
      chk_eq("rst_key_valid", 32'(key_valid), 32'h0);
      chk_eq("rst_key_held",  32'(key_held),  32'h0);
      chk_eq("rst_key_code",  32'(key_code),  32'h0);
      repeat (3) @(negedge clock_in);
      chk_eq("rst_hold_col_out", 32'(col_out), 32'h0000_000e);
      reset = 1'b0;
      cyc   = 0;
      model_clear();
   endtask

   initial begin
      reset = 1'b1;
      keys  = '0;
      cyc   = 0;
      model_clear();

      // Reset, idle column cycling with no keys.
      apply_reset();
      repeat (2) run_scan(16'h0000);

      // Key col2,row1 (code 9) stable: one pulse after 3rd scan, then held.
      repeat (4) run_scan(16'h0200);
      // Release: held drops after 3 empty scans, no pulse; re-press gives a new pulse.
      repeat (4) run_scan(16'h0000);
      repeat (4) run_scan(16'h0200);
      repeat (4) run_scan(16'h0000);

      // Two good scans then a gap: no acceptance.
      repeat (2) run_scan(16'h0200);
      repeat (2) run_scan(16'h0000);

      // Keys col0,row3 (code 3) and col1,row0 (code 4) together: lowest code wins.
      repeat (4) run_scan(16'h0018);
      repeat (4) run_scan(16'h0000);

      // Reset during press checking, then a full debounce is needed again.
      repeat (2) run_scan(16'h0200);
      apply_reset();
      repeat (4) run_scan(16'h0200);
      repeat (3) run_scan(16'h0000);

      // Randomized key sets, each held for a whole scan.
      rk = 16'h0000;
      for (int s = 0; s < 120; s++) begin
         case ($urandom_range(0, 9))
            0, 1:    rk = 16'h0000;
            2:       rk = 16'h0001 << $urandom_range(0, 15);
            3:       rk = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            4:       rk = 16'($urandom);
            default: rk = rk;
         endcase
         if (s == 70) apply_reset();
         run_scan(rk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
